// File: rtl/sprite_anim_sched_pkg.sv
// sprite_anim_pkg: shared types, constants and the orientation-to-row map
// for the Rojobot sprite animation scheduler.
package sprite_anim_pkg;

  localparam int NUM_FRAME_COLS = 3;
  localparam int NUM_FRAME_ROWS = 8;
  localparam logic [2:0] RESET_ROW = 3'd3;
  localparam logic [1:0] NEUTRAL_COL = 2'd1;

  typedef enum logic {
    ST_STILL,
    ST_WALK
  } anim_state_e;

  // Sprite sheet rows are not stored in compass order.
  function automatic logic [2:0] orient_to_row(input logic [2:0] orient);
    case (orient)
      3'd0: return 3'd1;
      3'd1: return 3'd7;
      3'd2: return 3'd3;
      3'd3: return 3'd5;
      3'd4: return 3'd0;
      3'd5: return 3'd4;
      3'd6: return 3'd2;
      default: return 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/sprite_anim_sched_if.sv
// sprite_anim_sched_if: bot register inputs and committed frame outputs of
// the sprite animation scheduler.
interface sprite_anim_sched_if;
  logic        vsync_pulse;
  logic        anim_en;
  logic [7:0]  BotInfo_reg;
  logic [7:0]  LocX_reg;
  logic [7:0]  LocY_reg;
  logic [2:0]  frame_row;
  logic [1:0]  frame_col;
  logic [15:0] row_base;
  logic [15:0] col_base;
  logic        moving;
  logic        frame_update;

  modport master (
    output vsync_pulse, anim_en, BotInfo_reg, LocX_reg, LocY_reg,
    input  frame_row, frame_col, row_base, col_base, moving, frame_update
  );

  modport slave (
    input  vsync_pulse, anim_en, BotInfo_reg, LocX_reg, LocY_reg,
    output frame_row, frame_col, row_base, col_base, moving, frame_update
  );
endinterface

// File: rtl/sprite_anim_sched_tick_gen.sv
// anim_tick_gen: animation step counter; pulses tick once every TICK_COUNT
// enabled cycles and holds at its reload value while disabled.
module anim_tick_gen #(
  parameter int TICK_COUNT = 35000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tick_o
);
  localparam int W = $clog2(TICK_COUNT);
  localparam logic [W-1:0] RELOAD = W'(TICK_COUNT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && cnt_q == '0;
  assign cnt_d  = (!en_i || tick_o) ? RELOAD : cnt_q - 1'b1;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= RELOAD;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/sprite_anim_sched.sv
// sprite_anim_sched: picks the sprite-sheet row/column for the Rojobot icon
// and commits it, with precomputed ROM bases, only on vertical sync.
module sprite_anim_sched
  import sprite_anim_pkg::*;
#(
  parameter int SCALING_FACTOR = 34,
  parameter int TICK_COUNT     = 35000000,
  parameter int IDLE_TICKS     = 4
) (
  input logic               clk,
  input logic               reset_n,
  sprite_anim_sched_if.slave bus
);
  if (7 * SCALING_FACTOR > 65535 || TICK_COUNT < 2 || IDLE_TICKS < 1 || IDLE_TICKS > 15)
  begin : g_param_chk
    $error("sprite_anim_sched: parameter out of range");
  end

  localparam logic [15:0] SF16 = 16'(SCALING_FACTOR);
  localparam logic [3:0]  IDLE_MAX = 4'(IDLE_TICKS);

  logic        tick, moved, commit, adv_dir_up, unused_bits;
  logic [1:0]  adv_col;
  anim_state_e state_q, state_d;
  logic [2:0]  pend_row_q, frame_row_q;
  logic [1:0]  pend_col_q, pend_col_d, frame_col_q;
  logic        dir_up_q, dir_up_d;
  logic [3:0]  idle_q, idle_d;
  logic [7:0]  last_x_q, last_y_q;
  logic [15:0] row_base_q, col_base_q;
  logic        moving_q, frame_update_q;

  anim_tick_gen #(.TICK_COUNT(TICK_COUNT)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (bus.anim_en),
    .tick_o (tick)
  );

  assign unused_bits = ^bus.BotInfo_reg[7:3];
  assign moved  = tick && (bus.LocX_reg != last_x_q || bus.LocY_reg != last_y_q);
  assign commit = bus.vsync_pulse && {pend_row_q, pend_col_q} != {frame_row_q, frame_col_q};

  // Ping-pong bounces at both ends within the same step, so 0..2 is never left.
  assign adv_col    = pend_col_q == 2'd1 ? (dir_up_q ? 2'd2 : 2'd0) : 2'd1;
  assign adv_dir_up = pend_col_q == 2'd2 ? 1'b0 : pend_col_q == 2'd0 ? 1'b1 : dir_up_q;

  always_comb begin
    state_d    = state_q;
    pend_col_d = pend_col_q;
    dir_up_d   = dir_up_q;
    idle_d     = idle_q;
    if (!bus.anim_en) begin
      state_d    = ST_STILL;
      pend_col_d = NEUTRAL_COL;
      idle_d     = '0;
    end else if (tick && state_q == ST_STILL) begin
      if (moved) begin
        state_d    = ST_WALK;
        pend_col_d = 2'd0;
        dir_up_d   = 1'b1;
        idle_d     = '0;
      end
    end else if (tick) begin
      if (!moved && idle_q == IDLE_MAX) begin
        state_d    = ST_STILL;
        pend_col_d = NEUTRAL_COL;
        idle_d     = '0;
      end else begin
        idle_d     = moved ? 4'd0 : idle_q + 4'd1;
        pend_col_d = adv_col;
        dir_up_d   = adv_dir_up;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q        <= ST_STILL;
      pend_row_q     <= RESET_ROW;
      pend_col_q     <= NEUTRAL_COL;
      dir_up_q       <= 1'b1;
      idle_q         <= '0;
      last_x_q       <= '0;
      last_y_q       <= '0;
      frame_row_q    <= RESET_ROW;
      frame_col_q    <= NEUTRAL_COL;
      row_base_q     <= 16'(RESET_ROW) * SF16;
      col_base_q     <= 16'(NEUTRAL_COL) * SF16;
      moving_q       <= 1'b0;
      frame_update_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_row_q     <= orient_to_row(bus.BotInfo_reg[2:0]);
      pend_col_q     <= pend_col_d;
      dir_up_q       <= dir_up_d;
      idle_q         <= idle_d;
      last_x_q       <= tick ? bus.LocX_reg : last_x_q;
      last_y_q       <= tick ? bus.LocY_reg : last_y_q;
      frame_row_q    <= commit ? pend_row_q : frame_row_q;
      frame_col_q    <= commit ? pend_col_q : frame_col_q;
      row_base_q     <= commit ? 16'(pend_row_q) * SF16 : row_base_q;
      col_base_q     <= commit ? 16'(pend_col_q) * SF16 : col_base_q;
      moving_q       <= state_d == ST_WALK;
      frame_update_q <= commit;
    end

  assign bus.frame_row    = frame_row_q;
  assign bus.frame_col    = frame_col_q;
  assign bus.row_base     = row_base_q;
  assign bus.col_base     = col_base_q;
  assign bus.moving       = moving_q;
  assign bus.frame_update = frame_update_q;
endmodule
